aes_mix_columns_seq: RTL and testbench

- Parametrised, handshaked AES MixColumns engine for the 128-bit state.
- Transforms COLS_PER_CYCLE columns per clock in place in an internal state register, so the design trades area against latency.
- Sits between ShiftRows and AddRoundKey in the round datapath.
- Uses valid/ready on both sides so round control can stall either end.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_mixcol_column.sv | 47 ++++
 rtl/aes_mix_columns_seq.sv | 112 +++++++++++
 tb/tb_aes_mix_columns_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - GF(2^8) helpers, state/column types and FSM states for MixColumns
package aes_pkg;

  localparam logic [7:0] AES_IRR_POLY = 8'h1B;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0] column_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_IRR_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul2(input byte_t a);
    return xtime(a);
  endfunction

  function automatic byte_t gf_mul3(input byte_t a);
    return xtime(a) ^ a;
  endfunction

  // Inverse coefficients are sums of a, 2a, 4a and 8a built from chained xtime.
  function automatic byte_t gf_mul9(input byte_t a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic byte_t gf_mulb(input byte_t a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic byte_t gf_muld(input byte_t a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic byte_t gf_mule(input byte_t a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/aes_mixcol_column.sv
// rtl/aes_mixcol_column.sv - combinational single-column MixColumns
// Inverse datapath only exists when AES_INV_MIXCOL_EN is defined.
module aes_mixcol_column
  import aes_pkg::*;
(
  input  column_t col_in,
  input  logic    inv,
  output column_t col_out
);

  function automatic byte_t fwd_row(input byte_t s0, input byte_t s1, input byte_t s2,
                                    input byte_t s3);
    return gf_mul2(s0) ^ gf_mul3(s1) ^ s2 ^ s3;
  endfunction

`ifdef AES_INV_MIXCOL_EN
  function automatic byte_t inv_row(input byte_t s0, input byte_t s1, input byte_t s2,
                                    input byte_t s3);
    return gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3);
  endfunction

  always_comb begin
    if (inv) begin
      col_out[0] = inv_row(col_in[0], col_in[1], col_in[2], col_in[3]);
      col_out[1] = inv_row(col_in[1], col_in[2], col_in[3], col_in[0]);
      col_out[2] = inv_row(col_in[2], col_in[3], col_in[0], col_in[1]);
      col_out[3] = inv_row(col_in[3], col_in[0], col_in[1], col_in[2]);
    end else begin
      col_out[0] = fwd_row(col_in[0], col_in[1], col_in[2], col_in[3]);
      col_out[1] = fwd_row(col_in[1], col_in[2], col_in[3], col_in[0]);
      col_out[2] = fwd_row(col_in[2], col_in[3], col_in[0], col_in[1]);
      col_out[3] = fwd_row(col_in[3], col_in[0], col_in[1], col_in[2]);
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv;

  always_comb begin
    col_out[0] = fwd_row(col_in[0], col_in[1], col_in[2], col_in[3]);
    col_out[1] = fwd_row(col_in[1], col_in[2], col_in[3], col_in[0]);
    col_out[2] = fwd_row(col_in[2], col_in[3], col_in[0], col_in[1]);
    col_out[3] = fwd_row(col_in[3], col_in[0], col_in[1], col_in[2]);
  end
`endif

endmodule

// File: rtl/aes_mix_columns_seq.sv
// rtl/aes_mix_columns_seq.sv - handshaked in-place MixColumns, COLS_PER_CYCLE columns per clock
// Define AES_INV_MIXCOL_EN to honour the inv input (InvMixColumns).
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'((NUM_STEPS - 1) * COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e       fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic         inv_q, inv_d;
  logic         in_ready_q, out_valid_q, busy_q;

  column_t    col_in  [COLS_PER_CYCLE];
  column_t    col_out [COLS_PER_CYCLE];
  logic [1:0] col_sel [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_sel[k] = col_idx_q + 2'(k);
    assign col_in[k]  = blk_q[32*col_sel[k] +: 32];

    aes_mixcol_column u_col (
      .col_in (col_in[k]),
      .inv    (inv_q),
      .col_out(col_out[k])
    );
  end

`ifndef AES_INV_MIXCOL_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    col_idx_d = col_idx_q;
    inv_d     = inv_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d     = in_data;
          col_idx_d = 2'd0;
`ifdef AES_INV_MIXCOL_EN
          inv_d     = inv;
`else
          inv_d     = 1'b0;
`endif
          fsm_d     = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          blk_d[32*col_sel[k] +: 32] = col_out[k];
        end
        col_idx_d = col_idx_q + IDX_STEP;
        if (col_idx_q == LAST_IDX) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next FSM state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      blk_q       <= '0;
      col_idx_q   <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      col_idx_q   <= col_idx_d;
      inv_q       <= inv_d;
      in_ready_q  <= (fsm_d == IDLE);
      out_valid_q <= (fsm_d == DONE);
      busy_q      <= (fsm_d == BUSY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = blk_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// tb/tb_aes_mix_columns_seq.sv - scoreboard bench for aes_mix_columns_seq at 1, 2 and 4 columns per cycle
// Inverse expectations follow AES_INV_MIXCOL_EN.
module tb_aes_mix_columns_seq;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_data   [NDUT];
  logic         inv       [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_data  [NDUT];
  logic         busy      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    aes_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .inv      (inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] exp_q[$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s, input logic use_inv);
    logic [7:0]   m [4];
    logic [7:0]   b [4];
    logic [7:0]   acc;
    logic [127:0] o;
    o = '0;
    if (use_inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) b[r] = s[8*(4*c+r) +: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[j], b[(r+j)%4]);
        o[8*(4*c+r) +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] col(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_out(input int d, output int n);
    n = 0;
    while (!out_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_block(input int d, input logic [127:0] din, input logic inv_i,
                           input logic [127:0] expv, input string tag);
    int n;
    logic [127:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = din;
    inv[d]      = inv_i;
    n = 0;
    while (!in_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 128'(in_ready[d]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    inv[d]      = 1'b0;
    wait_out(d, n);
    check({tag, "_latency"}, 128'(n), 128'(4 >> d));
    e = exp_q.pop_front();
    check({tag, "_data"}, out_data[d], e);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({tag, "_drop"}, 128'(out_valid[d]), 128'd0);
  endtask

  logic [127:0] s1, e1, f4, g4, r, f, e;
  int           n;

  initial begin
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      inv[d]       = 1'b0;
      out_ready[d] = 1'b0;
    end
    s1 = {col(8'hc6, 8'hc6, 8'hc6, 8'hc6), col(8'h01, 8'h01, 8'h01, 8'h01),
          col(8'hf2, 8'h0a, 8'h22, 8'h5c), col(8'hdb, 8'h13, 8'h53, 8'h45)};
    e1 = {col(8'hc6, 8'hc6, 8'hc6, 8'hc6), col(8'h01, 8'h01, 8'h01, 8'h01),
          col(8'h9f, 8'hdc, 8'h58, 8'h9d), col(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
    f4 = {4{col(8'hd4, 8'hbf, 8'h5d, 8'h30)}};
    g4 = {4{col(8'h04, 8'h66, 8'h81, 8'he5)}};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_in_ready_%0d", d), 128'(in_ready[d]), 128'd1);
      check($sformatf("reset_out_valid_%0d", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("reset_busy_%0d", d), 128'(busy[d]), 128'd0);
      check($sformatf("reset_out_data_%0d", d), out_data[d], 128'd0);
    end

    for (int d = 0; d < NDUT; d++) begin
      run_block(d, s1, 1'b0, e1, $sformatf("fwd_vec_d%0d", d));
      run_block(d, f4, 1'b0, g4, $sformatf("fips_fwd_d%0d", d));
`ifdef AES_INV_MIXCOL_EN
      run_block(d, g4, 1'b1, f4, $sformatf("fips_inv_d%0d", d));
`else
      run_block(d, f4, 1'b1, g4, $sformatf("inv_ignored_d%0d", d));
`endif
      r = {$urandom, $urandom, $urandom, $urandom};
      f = model_mix(r, 1'b0);
      run_block(d, r, 1'b0, f, $sformatf("rand_fwd_d%0d", d));
`ifdef AES_INV_MIXCOL_EN
      run_block(d, f, 1'b1, r, $sformatf("rand_roundtrip_d%0d", d));
`else
      run_block(d, r, 1'b1, f, $sformatf("rand_inv_ignored_d%0d", d));
`endif
    end

    // Backpressure in DONE with a second block already waiting on in_valid.
    exp_q.push_back(e1);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = s1;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = f4;
    exp_q.push_back(g4);
    check("bp_busy", 128'(busy[0]), 128'd1);
    wait_out(0, n);
    check("bp_latency", 128'(n), 128'd4);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_data_%0d", i), out_data[0], e);
      check($sformatf("bp_hold_valid_%0d", i), 128'(out_valid[0]), 128'd1);
      check($sformatf("bp_hold_in_ready_%0d", i), 128'(in_ready[0]), 128'd0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_no_early_accept", 128'(busy[0]), 128'd0);
    check("bp_idle_in_ready", 128'(in_ready[0]), 128'd1);
    check("bp_idle_out_valid", 128'(out_valid[0]), 128'd0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_second_accept", 128'(busy[0]), 128'd1);
    wait_out(0, n);
    check("bp_second_latency", 128'(n), 128'd4);
    e = exp_q.pop_front();
    check("bp_second_data", out_data[0], e);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset while BUSY with col_idx at 2.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = s1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_mid_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_mid_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_mid_out_data", out_data[0], 128'd0);
    check("rst_mid_busy", 128'(busy[0]), 128'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid_no_output_%0d", i), 128'(out_valid[0]), 128'd0);
    end
    r = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, r, 1'b0, model_mix(r, 1'b0), "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
